// File: rtl/draw_scheduler_if.sv
// draw_scheduler_if: command-stack, loader, stencil and status signals of the draw scheduler
interface draw_scheduler_if #(
    parameter int CHAR_ID_WIDTH = 6,
    parameter int VGA_X_WIDTH   = 10,
    parameter int VGA_Y_WIDTH   = 10,
    parameter int COUNT_WIDTH   = 16
);
    logic                     enable;
    logic                     stack_empty;
    logic                     pop;
    logic [CHAR_ID_WIDTH-1:0] cmd_id;
    logic [VGA_X_WIDTH-1:0]   cmd_x;
    logic [VGA_Y_WIDTH-1:0]   cmd_y;
    logic                     load;
    logic [CHAR_ID_WIDTH-1:0] load_character_id;
    logic [VGA_X_WIDTH-1:0]   load_x;
    logic [VGA_Y_WIDTH-1:0]   load_y;
    logic                     load_finish;
    logic                     draw;
    logic                     draw_finish;
    logic                     vblank;
    logic                     clear_error;
    logic                     busy;
    logic                     error;
    logic [COUNT_WIDTH-1:0]   job_count;

    modport master (
        input  enable, stack_empty, cmd_id, cmd_x, cmd_y, load_finish, draw_finish, vblank, clear_error,
        output pop, load, load_character_id, load_x, load_y, draw, busy, error, job_count
    );

    modport slave (
        output enable, stack_empty, cmd_id, cmd_x, cmd_y, load_finish, draw_finish, vblank, clear_error,
        input  pop, load, load_character_id, load_x, load_y, draw, busy, error, job_count
    );
endinterface

// File: rtl/draw_scheduler.sv
// draw_scheduler: pops one glyph command, runs loader then stencil draw, optionally gated to vblank
module draw_scheduler #(
    parameter int CHAR_ID_WIDTH = 6,
    parameter int VGA_X_WIDTH   = 10,
    parameter int VGA_Y_WIDTH   = 10,
    parameter int VBLANK_ONLY   = 1,
    parameter int TIMEOUT       = 4096,
    parameter int COUNT_WIDTH   = 16
) (
    input logic              clock,
    input logic              reset,
    draw_scheduler_if.master bus
);
    localparam int TW = $clog2(TIMEOUT);

    typedef enum logic [2:0] {IDLE, POP, FETCH, LOAD, WAIT_LOAD, WAIT_SLOT, DRAW, WAIT_DRAW} state_t;

    state_t                   state_q, state_d;
    logic [TW-1:0]            timer_q, timer_d;
    logic [CHAR_ID_WIDTH-1:0] id_q, id_d;
    logic [VGA_X_WIDTH-1:0]   x_q, x_d;
    logic [VGA_Y_WIDTH-1:0]   y_q, y_d;
    logic [COUNT_WIDTH-1:0]   count_q, count_d;
    logic                     pop_q, load_q, draw_q, busy_q, error_q;
    logic                     timeout;
    logic                     expired;

    assign expired = (timer_q == TW'(TIMEOUT - 1));

    // next-state, job latching, watchdog timer and completion counting
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        id_d    = id_q;
        x_d     = x_q;
        y_d     = y_q;
        count_d = count_q;
        timeout = 1'b0;
        case (state_q)
            IDLE:      state_d = (bus.enable && !bus.stack_empty) ? POP : IDLE;
            POP:       state_d = FETCH;
            FETCH: begin
                id_d    = bus.cmd_id;
                x_d     = bus.cmd_x;
                y_d     = bus.cmd_y;
                state_d = LOAD;
            end
            LOAD: begin
                timer_d = '0;
                state_d = WAIT_LOAD;
            end
            WAIT_LOAD: begin
                timeout = !bus.load_finish && expired;
                timer_d = timer_q + 1'b1;
                state_d = bus.load_finish ? WAIT_SLOT : expired ? IDLE : WAIT_LOAD;
            end
            WAIT_SLOT: state_d = (VBLANK_ONLY == 0 || bus.vblank) ? DRAW : WAIT_SLOT;
            DRAW: begin
                timer_d = '0;
                state_d = WAIT_DRAW;
            end
            WAIT_DRAW: begin
                timeout = !bus.draw_finish && expired;
                timer_d = timer_q + 1'b1;
                count_d = bus.draw_finish ? count_q + 1'b1 : count_q;
                state_d = (bus.draw_finish || expired) ? IDLE : WAIT_DRAW;
            end
            default:   state_d = IDLE;
        endcase
    end

    // state, job registers and registered strobes/status derived from the next state
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            timer_q <= '0;
            id_q    <= '0;
            x_q     <= '0;
            y_q     <= '0;
            count_q <= '0;
            pop_q   <= 1'b0;
            load_q  <= 1'b0;
            draw_q  <= 1'b0;
            busy_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            id_q    <= id_d;
            x_q     <= x_d;
            y_q     <= y_d;
            count_q <= count_d;
            pop_q   <= (state_d == POP);
            load_q  <= (state_d == LOAD);
            draw_q  <= (state_d == DRAW);
            busy_q  <= (state_d != IDLE);
            error_q <= timeout || (error_q && !bus.clear_error);
        end
    end

    assign bus.pop               = pop_q;
    assign bus.load              = load_q;
    assign bus.draw              = draw_q;
    assign bus.busy              = busy_q;
    assign bus.error             = error_q;
    assign bus.job_count         = count_q;
    assign bus.load_character_id = id_q;
    assign bus.load_x            = x_q;
    assign bus.load_y            = y_q;
endmodule

// File: tb/tb_draw_scheduler.sv
// tb_draw_scheduler: stack/loader/stencil models with a scoreboard of expected load commands
module tb_draw_scheduler;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int checks = 0;
    int errors = 0;

    draw_scheduler_if #(.CHAR_ID_WIDTH(6), .VGA_X_WIDTH(10), .VGA_Y_WIDTH(10), .COUNT_WIDTH(16)) bus ();

    draw_scheduler #(
        .CHAR_ID_WIDTH(6), .VGA_X_WIDTH(10), .VGA_Y_WIDTH(10),
        .VBLANK_ONLY(1), .TIMEOUT(16), .COUNT_WIDTH(16)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus)
    );

    always #5 clock = ~clock;

    // command stack model: data appears the cycle after pop
    logic [25:0] stk [16];
    logic [3:0]  wr_ptr = '0;
    logic [3:0]  rd_ptr = '0;
    logic [25:0] cmd_r = '0;
    always @(posedge clock) begin
        if (bus.pop === 1'b1) begin
            cmd_r  <= stk[rd_ptr];
            rd_ptr <= rd_ptr + 4'd1;
        end
    end
    assign bus.stack_empty = (wr_ptr == rd_ptr);
    assign {bus.cmd_id, bus.cmd_x, bus.cmd_y} = cmd_r;

    // loader/stencil responders: finish N cycles after the strobe, 0 = never
    int   load_delay = 1, draw_delay = 1, lcnt = 0, dcnt = 0;
    logic resp_load = 1'b0, resp_draw = 1'b0, stray_load = 1'b0, stray_draw = 1'b0;
    always @(negedge clock) begin
        resp_load = 1'b0;
        resp_draw = 1'b0;
        if (lcnt > 0) begin lcnt = lcnt - 1; resp_load = (lcnt == 0); end
        if (dcnt > 0) begin dcnt = dcnt - 1; resp_draw = (dcnt == 0); end
        if (bus.load === 1'b1 && load_delay > 0) lcnt = load_delay;
        if (bus.draw === 1'b1 && draw_delay > 0) dcnt = draw_delay;
    end
    assign bus.load_finish = resp_load | stray_load;
    assign bus.draw_finish = resp_draw | stray_draw;

    // output monitor
    int          cyc = 0;
    int          pop_cyc [$];
    logic [25:0] load_obs [$];
    int          draw_cnt = 0;
    always @(posedge clock) cyc <= cyc + 1;
    always @(negedge clock) begin
        if (bus.pop === 1'b1) pop_cyc.push_back(cyc);
        if (bus.load === 1'b1) load_obs.push_back({bus.load_character_id, bus.load_x, bus.load_y});
        if (bus.draw === 1'b1) draw_cnt++;
    end

    // scoreboard
    logic [25:0] exp_q [$];
    int          ld_rd = 0;

    task automatic push_cmd(input logic [5:0] id, input logic [9:0] x, input logic [9:0] y);
        stk[wr_ptr] = {id, x, y};
        wr_ptr = wr_ptr + 4'd1;
        exp_q.push_back({id, x, y});
    endtask

    task automatic test_reset;
        bus.enable = 1'b0;
        bus.vblank = 1'b1;
        bus.clear_error = 1'b0;
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({bus.pop, bus.load, bus.draw, bus.busy, bus.error} !== 5'b0) begin
            errors++; $display("FAIL reset_strobes got %b exp 00000", {bus.pop, bus.load, bus.draw, bus.busy, bus.error});
        end
        checks++;
        if (bus.job_count !== 16'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", bus.job_count); end
        checks++;
        if ({bus.load_character_id, bus.load_x, bus.load_y} !== 26'd0) begin
            errors++; $display("FAIL reset_job got %h exp 0", {bus.load_character_id, bus.load_x, bus.load_y});
        end
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_single;
        int p0 = pop_cyc.size();
        int d0 = draw_cnt;
        logic [25:0] got, exp;
        load_delay = 3; draw_delay = 3; bus.vblank = 1'b1; bus.enable = 1'b1;
        push_cmd(6'h2A, 10'd100, 10'd200);
        for (int i = 0; i < 100 && bus.job_count !== 16'd1; i++) @(negedge clock);
        repeat (2) @(negedge clock);
        checks++;
        if (bus.job_count !== 16'd1) begin errors++; $display("FAIL single_count got %0d exp 1", bus.job_count); end
        checks++;
        if (pop_cyc.size() - p0 != 1) begin errors++; $display("FAIL single_pops got %0d exp 1", pop_cyc.size() - p0); end
        checks++;
        if (draw_cnt - d0 != 1) begin errors++; $display("FAIL single_draws got %0d exp 1", draw_cnt - d0); end
        checks++;
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL single_busy got %b exp 0", bus.busy); end
        checks++;
        exp = exp_q.pop_front();
        got = (load_obs.size() > ld_rd) ? load_obs[ld_rd] : 26'h3ffffff;
        ld_rd++;
        if (got !== exp) begin errors++; $display("FAIL single_load got %h exp %h", got, exp); end
    endtask

    task automatic test_vblank_gating;
        int d0 = draw_cnt;
        logic [25:0] got, exp;
        load_delay = 1; draw_delay = 1; bus.vblank = 1'b0;
        push_cmd(6'h15, 10'd639, 10'd479);
        for (int i = 0; i < 20 && bus.load !== 1'b1; i++) @(negedge clock);
        repeat (50) @(negedge clock);
        checks++;
        if (draw_cnt - d0 != 0 || bus.busy !== 1'b1) begin
            errors++; $display("FAIL vblank_hold got draws=%0d busy=%b exp draws=0 busy=1", draw_cnt - d0, bus.busy);
        end
        bus.vblank = 1'b1;
        @(negedge clock);
        checks++;
        if (bus.draw !== 1'b1) begin errors++; $display("FAIL vblank_draw_rise got %b exp 1", bus.draw); end
        @(negedge clock);
        checks++;
        if (bus.draw !== 1'b0) begin errors++; $display("FAIL vblank_draw_width got %b exp 0", bus.draw); end
        for (int i = 0; i < 50 && bus.job_count !== 16'd2; i++) @(negedge clock);
        checks++;
        if (bus.job_count !== 16'd2 || draw_cnt - d0 != 1) begin
            errors++; $display("FAIL vblank_done got count=%0d draws=%0d exp count=2 draws=1", bus.job_count, draw_cnt - d0);
        end
        checks++;
        exp = exp_q.pop_front();
        got = (load_obs.size() > ld_rd) ? load_obs[ld_rd] : 26'h3ffffff;
        ld_rd++;
        if (got !== exp) begin errors++; $display("FAIL vblank_load got %h exp %h", got, exp); end
    endtask

    task automatic test_back_to_back;
        int p0 = pop_cyc.size();
        int g1, g2;
        logic [25:0] got, exp;
        load_delay = 1; draw_delay = 1;
        push_cmd(6'h01, 10'd0, 10'd0);
        push_cmd(6'h3F, 10'd1023, 10'd1023);
        push_cmd(6'h22, 10'd512, 10'd7);
        for (int i = 0; i < 200 && bus.job_count !== 16'd5; i++) @(negedge clock);
        repeat (20) @(negedge clock);
        checks++;
        if (bus.job_count !== 16'd5) begin errors++; $display("FAIL b2b_count got %0d exp 5", bus.job_count); end
        checks++;
        if (pop_cyc.size() - p0 != 3) begin errors++; $display("FAIL b2b_pops got %0d exp 3", pop_cyc.size() - p0); end
        g1 = (pop_cyc.size() > p0 + 1) ? pop_cyc[p0 + 1] - pop_cyc[p0] : -1;
        g2 = (pop_cyc.size() > p0 + 2) ? pop_cyc[p0 + 2] - pop_cyc[p0 + 1] : -1;
        checks++;
        if (g1 != 8 || g2 != 8) begin errors++; $display("FAIL b2b_spacing got %0d,%0d exp 8,8", g1, g2); end
        for (int k = 0; k < 3; k++) begin
            checks++;
            exp = exp_q.pop_front();
            got = (load_obs.size() > ld_rd) ? load_obs[ld_rd] : 26'h3ffffff;
            ld_rd++;
            if (got !== exp) begin errors++; $display("FAIL b2b_load%0d got %h exp %h", k, got, exp); end
        end
    endtask

    task automatic test_timeout;
        logic [15:0] jc = bus.job_count;
        logic [25:0] got, exp;
        load_delay = 0;
        push_cmd(6'h0C, 10'd33, 10'd44);
        for (int i = 0; i < 20 && bus.load !== 1'b1; i++) @(negedge clock);
        repeat (16) @(negedge clock);
        checks++;
        if (bus.error !== 1'b0 || bus.busy !== 1'b1) begin
            errors++; $display("FAIL timeout_early got error=%b busy=%b exp error=0 busy=1", bus.error, bus.busy);
        end
        @(negedge clock);
        checks++;
        if (bus.error !== 1'b1 || bus.busy !== 1'b0 || bus.job_count !== jc) begin
            errors++; $display("FAIL timeout_hit got error=%b busy=%b count=%0d exp error=1 busy=0 count=%0d", bus.error, bus.busy, bus.job_count, jc);
        end
        checks++;
        exp = exp_q.pop_front();
        got = (load_obs.size() > ld_rd) ? load_obs[ld_rd] : 26'h3ffffff;
        ld_rd++;
        if (got !== exp) begin errors++; $display("FAIL timeout_load got %h exp %h", got, exp); end
        load_delay = 1;
        push_cmd(6'h0D, 10'd34, 10'd45);
        for (int i = 0; i < 50 && bus.job_count !== jc + 16'd1; i++) @(negedge clock);
        checks++;
        if (bus.job_count !== jc + 16'd1 || bus.error !== 1'b1) begin
            errors++; $display("FAIL timeout_next got count=%0d error=%b exp count=%0d error=1", bus.job_count, bus.error, jc + 16'd1);
        end
        checks++;
        exp = exp_q.pop_front();
        got = (load_obs.size() > ld_rd) ? load_obs[ld_rd] : 26'h3ffffff;
        ld_rd++;
        if (got !== exp) begin errors++; $display("FAIL timeout_next_load got %h exp %h", got, exp); end
        bus.clear_error = 1'b1;
        @(negedge clock);
        bus.clear_error = 1'b0;
        checks++;
        if (bus.error !== 1'b0) begin errors++; $display("FAIL clear_error got %b exp 0", bus.error); end
    endtask

    task automatic test_race;
        logic [15:0] jc = bus.job_count;
        int p0, l0;
        logic [25:0] got, exp;
        load_delay = 1; draw_delay = 16;
        push_cmd(6'h2B, 10'd300, 10'd150);
        for (int i = 0; i < 100 && bus.job_count !== jc + 16'd1; i++) @(negedge clock);
        repeat (2) @(negedge clock);
        checks++;
        if (bus.job_count !== jc + 16'd1 || bus.error !== 1'b0) begin
            errors++; $display("FAIL race_finish got count=%0d error=%b exp count=%0d error=0", bus.job_count, bus.error, jc + 16'd1);
        end
        checks++;
        exp = exp_q.pop_front();
        got = (load_obs.size() > ld_rd) ? load_obs[ld_rd] : 26'h3ffffff;
        ld_rd++;
        if (got !== exp) begin errors++; $display("FAIL race_load got %h exp %h", got, exp); end
        p0 = pop_cyc.size(); l0 = load_obs.size(); jc = bus.job_count;
        stray_load = 1'b1; stray_draw = 1'b1;
        @(negedge clock);
        stray_load = 1'b0; stray_draw = 1'b0;
        repeat (4) @(negedge clock);
        checks++;
        if (bus.busy !== 1'b0 || bus.error !== 1'b0 || bus.job_count !== jc || pop_cyc.size() != p0 || load_obs.size() != l0) begin
            errors++; $display("FAIL stray_finish got busy=%b error=%b count=%0d exp busy=0 error=0 count=%0d", bus.busy, bus.error, bus.job_count, jc);
        end
        draw_delay = 1;
    endtask

    task automatic test_reset_mid;
        logic [25:0] got, exp;
        load_delay = 1; draw_delay = 0;
        push_cmd(6'h33, 10'd9, 10'd99);
        for (int i = 0; i < 50 && bus.draw !== 1'b1; i++) @(negedge clock);
        checks++;
        if (bus.draw !== 1'b1) begin errors++; $display("FAIL mid_draw_seen got %b exp 1", bus.draw); end
        repeat (3) @(negedge clock);
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({bus.pop, bus.load, bus.draw, bus.busy, bus.error} !== 5'b0 || bus.job_count !== 16'd0) begin
            errors++; $display("FAIL mid_reset got strobes=%b count=%0d exp strobes=00000 count=0", {bus.pop, bus.load, bus.draw, bus.busy, bus.error}, bus.job_count);
        end
        checks++;
        exp = exp_q.pop_front();
        got = (load_obs.size() > ld_rd) ? load_obs[ld_rd] : 26'h3ffffff;
        ld_rd++;
        if (got !== exp) begin errors++; $display("FAIL mid_load got %h exp %h", got, exp); end
        @(negedge clock);
        reset = 1'b1;
        draw_delay = 1;
        push_cmd(6'h07, 10'd70, 10'd80);
        for (int i = 0; i < 50 && bus.job_count !== 16'd1; i++) @(negedge clock);
        checks++;
        if (bus.job_count !== 16'd1) begin errors++; $display("FAIL mid_restart got %0d exp 1", bus.job_count); end
        checks++;
        exp = exp_q.pop_front();
        got = (load_obs.size() > ld_rd) ? load_obs[ld_rd] : 26'h3ffffff;
        ld_rd++;
        if (got !== exp) begin errors++; $display("FAIL mid_restart_load got %h exp %h", got, exp); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_vblank_gating();
        test_back_to_back();
        test_timeout();
        test_race();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/draw_scheduler.md
Name: draw_scheduler

Overview:
- Sequencer between the character command stack and the loader/stencil datapath.
- Pops one character draw command at a time, hands it to the loader, then fires the stencil draw into the screen buffer.
- Can hold the draw phase until vertical blanking so the scan-out never sees a half-drawn glyph.
- Timeout watchdog on both handshakes; job counter and sticky error for debug.

Parameters:
- CHAR_ID_WIDTH, 6, width of character id
- VGA_X_WIDTH, 10, width of x coordinate
- VGA_Y_WIDTH, 10, width of y coordinate
- VBLANK_ONLY, 1, 1 = draw only while vblank high; 0 = draw immediately
- TIMEOUT, 4096, max cycles waited for load_finish or draw_finish (>=2)
- COUNT_WIDTH, 16, width of completed-job counter

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- enable  in  1  1 = scheduler may start new jobs
- stack_empty  in  1  command stack empty
- pop  out  1  one-cycle pop strobe to stack
- cmd_id  in  CHAR_ID_WIDTH  stack output, valid cycle after pop
- cmd_x  in  VGA_X_WIDTH  stack output x
- cmd_y  in  VGA_Y_WIDTH  stack output y
- load  out  1  one-cycle start strobe to loader
- load_character_id  out  CHAR_ID_WIDTH  registered job id to loader
- load_x  out  VGA_X_WIDTH  registered job x
- load_y  out  VGA_Y_WIDTH  registered job y
- load_finish  in  1  loader done pulse
- draw  out  1  one-cycle start strobe to stencil/buffer
- draw_finish  in  1  stencil done pulse
- vblank  in  1  vertical blanking active
- clear_error  in  1  synchronous clear of error
- busy  out  1  high in every state except IDLE
- error  out  1  sticky: a job timed out
- job_count  out  COUNT_WIDTH  completed jobs, wraps

Behaviour:
- Reset (reset low, async): state IDLE; pop, load, draw, busy, error = 0; load_character_id/x/y = 0; job_count = 0; timer = 0. Release is synchronous to clock.
- All outputs are registered. Strobes are exactly one cycle wide.
- IDLE: if enable && !stack_empty, assert pop next cycle and go to POP. Otherwise stay.
- POP: pop=1 for this cycle only; go to FETCH.
- FETCH: latch cmd_id/cmd_x/cmd_y into load_character_id/load_x/load_y; go to LOAD.
- LOAD: load=1 for one cycle; clear timer; go to WAIT_LOAD.
- WAIT_LOAD:
  - load_finish -> WAIT_SLOT.
  - Else timer increments; when timer reaches TIMEOUT-1 without finish -> set error, go to IDLE (job dropped, not counted).
- WAIT_SLOT: if VBLANK_ONLY==0 or vblank==1 -> DRAW. No timeout here; waits indefinitely.
- DRAW: draw=1 for one cycle; clear timer; go to WAIT_DRAW.
- WAIT_DRAW:
  - draw_finish -> job_count+1 (wraps modulo 2^COUNT_WIDTH), go to IDLE.
  - Timeout rule identical to WAIT_LOAD.
- Minimum job: IDLE->POP->FETCH->LOAD->WAIT_LOAD->WAIT_SLOT->DRAW->WAIT_DRAW->IDLE. With 1-cycle finish responses and vblank high, pop-to-pop spacing is 8 cycles.
- Finish arriving on the same cycle timer hits TIMEOUT-1: finish wins, no error.
- load_finish/draw_finish outside their wait state: ignored, no state change.
- enable deasserted mid-job: current job runs to completion; no new pop afterwards.
- stack_empty is only sampled in IDLE. The loader/stencil addresses are owned by the active job; load_* outputs stay stable from FETCH until the next FETCH.
- clear_error: clears error next cycle. If a timeout occurs the same cycle, error stays set (set wins).
- Mid-operation reset: immediate return to IDLE with all strobes low. An outstanding stack entry already popped is lost by design.

Test Plan:
- Single job: push id=0x2A, x=100, y=200; vblank=1; loader/stencil finish 3 cycles after strobes -> one pop; load with id=0x2A/100/200; draw once; job_count=1; busy low after.
- VBLANK gating: VBLANK_ONLY=1, vblank=0 for 50 cycles after load_finish -> draw stays 0 until the cycle after vblank rises, then a single 1-cycle draw pulse.
- Back-to-back: 3 entries, immediate finishes -> 3 pops spaced 8 cycles; job_count=3; stack_empty stops further pops.
- Timeout: TIMEOUT=16, load_finish never arrives -> error=1 on the 16th wait cycle; state IDLE; job_count unchanged; next job proceeds. clear_error -> error=0.
- Race: draw_finish on the exact timeout cycle -> no error, job_count increments. Stray load_finish in IDLE -> no effect.
- Reset mid WAIT_DRAW: pull reset low asynchronously -> draw/load/pop/busy=0 immediately; job_count=0; after release, the scheduler restarts from IDLE.
